// File: rtl/result_writeback.sv
// result_writeback: captures a wide result vector and its SRAM base address on
// a capture strobe, then streams it to result SRAM as NBEATS address-ordered
// beats over a valid/ready port. A new result can be captured in the same
// cycle the last beat is accepted, so back-to-back results leave no idle gap.
// A strobe that arrives while a result is still being written is dropped and
// recorded in a sticky overflow flag.
module result_writeback #(
  parameter int RESULT_W = 8192,
  parameter int BEAT_W   = 1024,
  parameter int ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sram_en,
  input  logic [ADDR_W-1:0]   sram_write_address,
  input  logic [RESULT_W-1:0] sram_result,
  output logic                mem_wvalid,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [BEAT_W-1:0]   mem_wdata,
  input  logic                mem_wready,
  output logic                busy,
  output logic                wb_done,
  output logic                overflow,
  output logic [15:0]         result_cnt
);

  localparam int NBEATS = RESULT_W / BEAT_W;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [IDX_W-1:0]    beat_idx_r;
  logic [RESULT_W-1:0] cap_r;

  logic                hs_s;
  logic                last_s;
  logic                in_ready_s;
  logic                capture_s;
  logic [IDX_W-1:0]    idx_inc_s;

  logic                wvalid_nxt_s;
  logic [ADDR_W-1:0]   waddr_nxt_s;
  logic [BEAT_W-1:0]   wdata_nxt_s;
  logic [IDX_W-1:0]    idx_nxt_s;
  logic [RESULT_W-1:0] cap_nxt_s;
  logic                busy_nxt_s;
  logic                wb_done_nxt_s;
  logic                overflow_nxt_s;
  logic [15:0]         cnt_nxt_s;

  // Handshake and capture qualification shared by the FSM and the datapath.
  always_comb begin
    hs_s       = mem_wvalid & mem_wready;
    last_s     = (beat_idx_r == LAST_IDX);
    in_ready_s = (state_r == IDLE) | ((state_r == WRITE) & hs_s & last_s);
    capture_s  = sram_en & in_ready_s;
    idx_inc_s  = beat_idx_r + IDX_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: leave WRITE only once the last beat is accepted and no new result follows.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (hs_s && last_s) begin
          state_nxt_s = capture_s ? WRITE : IDLE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM outputs: next values of the registered beat port, counters and flags.
  always_comb begin
    wvalid_nxt_s   = mem_wvalid;
    waddr_nxt_s    = mem_waddr;
    wdata_nxt_s    = mem_wdata;
    idx_nxt_s      = beat_idx_r;
    cap_nxt_s      = cap_r;
    busy_nxt_s     = (state_nxt_s == WRITE);
    wb_done_nxt_s  = 1'b0;
    overflow_nxt_s = overflow | (sram_en & ~in_ready_s);
    cnt_nxt_s      = result_cnt;

    if (capture_s) begin
      // New result: present beat 0 on the very next cycle.
      cap_nxt_s    = sram_result;
      wvalid_nxt_s = 1'b1;
      waddr_nxt_s  = sram_write_address;
      wdata_nxt_s  = sram_result[BEAT_W-1:0];
      idx_nxt_s    = '0;
    end else if (hs_s && !last_s) begin
      // Advance to the next slice; address wraps naturally at 2^ADDR_W.
      idx_nxt_s    = idx_inc_s;
      waddr_nxt_s  = mem_waddr + ADDR_W'(1);
      wdata_nxt_s  = cap_r[int'(idx_inc_s) * BEAT_W +: BEAT_W];
    end else if (hs_s && last_s) begin
      wvalid_nxt_s = 1'b0;
    end else begin
      // Stalled or idle: hold the presented beat stable.
      wvalid_nxt_s = mem_wvalid;
    end

    if (hs_s && last_s) begin
      wb_done_nxt_s = 1'b1;
      cnt_nxt_s     = result_cnt + 16'd1;
    end else begin
      wb_done_nxt_s = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wvalid <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      beat_idx_r <= '0;
      cap_r      <= '0;
      busy       <= 1'b0;
      wb_done    <= 1'b0;
      overflow   <= 1'b0;
      result_cnt <= 16'd0;
    end else begin
      mem_wvalid <= wvalid_nxt_s;
      mem_waddr  <= waddr_nxt_s;
      mem_wdata  <= wdata_nxt_s;
      beat_idx_r <= idx_nxt_s;
      cap_r      <= cap_nxt_s;
      busy       <= busy_nxt_s;
      wb_done    <= wb_done_nxt_s;
      overflow   <= overflow_nxt_s;
      result_cnt <= cnt_nxt_s;
    end
  end

endmodule
